uart_tx: RTL
============

Name: uart_tx

Overview:
UART transmitter that serializes one parallel byte per frame onto a single TX line: start bit, LSB-first data, optional parity, then stop. It is the transmit-side counterpart to the UART RX path and shares its Prescale convention: each bit lasts Prescale clk cycles. An internal FSM drives sequencing; a per-bit cycle counter and a bit index counter handle timing.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
Prescale_width, 6, width of Prescale input and internal cycle counter

Ports:
clk  input  1  system clock, all logic on rising edge
reset_n  input  1  synchronous active-low reset, sampled on rising clk
Prescale  input  Prescale_width  clk cycles per bit; latched at frame acceptance; 0 treated as 1
P_DATA  input  DATA_WIDTH  byte to transmit
Data_Valid  input  1  request to send P_DATA
PAR_EN  input  1  1 = append parity bit; latched at acceptance
PAR_TYP  input  1  0 = even, 1 = odd parity; latched at acceptance
TX_OUT  output  1  serial line, idle high, registered
Busy  output  1  high while a frame is in progress, registered

Behaviour:
- Reset (reset_n=0 at rising clk): state=IDLE, TX_OUT=1, Busy=0, all counters and latches cleared. Reset takes priority over everything, including mid-frame; the frame is abandoned with no further bits.
- FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: TX_OUT=1, Busy=0. If Data_Valid=1 at a rising edge:
  - latch P_DATA, Prescale, PAR_EN and PAR_TYP;
  - compute parity = XOR of data bits, XOR PAR_TYP;
  - go to START.
  TX_OUT=0 and Busy=1 from the next cycle (1-cycle latency).
- Each non-IDLE state holds its TX_OUT value for exactly Prescale_latched cycles. The cycle counter counts 0..Prescale_latched-1 and resets to 0 on each bit boundary.
- START: TX_OUT=0. Then go to DATA with bit index 0.
- DATA: TX_OUT=data[bit index], LSB first. After DATA_WIDTH bits, go to PARITY if PAR_EN_latched, else STOP.
- PARITY: TX_OUT=parity bit, then go to STOP.
- STOP: TX_OUT=1. At the end of the last stop cycle go to IDLE; Busy=0 from the next cycle.
- Frame length: (DATA_WIDTH+2+PAR_EN)*Prescale cycles, with Busy=1 for exactly that many cycles.
- Data_Valid while Busy=1 is ignored (no queueing). Input changes mid-frame have no effect.
- Back-to-back: acceptance is possible in the first IDLE cycle, so at least 1 idle-high cycle separates frames.
- Counters never wrap beyond Prescale_latched-1 or DATA_WIDTH-1.

Optional Feature:
UART_TX_STOP2_EN
- Defined: the STOP state lasts 2*Prescale_latched cycles (two stop bits). Frame length is (DATA_WIDTH+3+PAR_EN)*Prescale.
- Undefined: one stop bit, as described above.

Test Plan:
- Prescale=8, P_DATA=0xA5, PAR_EN=1, PAR_TYP=0 -> TX_OUT bit sequence 0,1,0,1,0,0,1,0,1,0,1, each bit 8 cycles; Busy high exactly 88 cycles; parity bit 0.
- Same frame with PAR_TYP=1 -> parity bit 1; all other bits identical.
- Prescale=4, P_DATA=0x3C, PAR_EN=0 -> sequence 0,0,0,1,1,1,1,0,0,1; Busy high 40 cycles.
- Pulse Data_Valid with P_DATA=0xFF mid-frame while sending 0x00 -> 0x00 frame unaltered; no second frame starts.
- Prescale=1, Data_Valid held high with P_DATA=0x55, PAR_EN=0 -> 10-cycle frames separated by exactly 1 idle-high cycle.
- reset_n=0 during the 3rd data bit -> next cycle TX_OUT=1, Busy=0, state IDLE; a new request after release sends a complete, correct frame.
- With UART_TX_STOP2_EN defined, Prescale=8, 0xA5 with parity -> stop high 16 cycles; Busy high 96 cycles.

Source files
------------

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start bit, LSB-first data, optional parity, stop bit(s)
//
// Serializes one DATA_WIDTH-bit word per frame onto TX_OUT. Every bit lasts
// Prescale clk cycles, where Prescale is latched when the frame is accepted
// and a value of 0 is treated as 1.
//
// Optional feature macro: UART_TX_STOP2_EN
//   defined   - two stop bits (STOP state lasts 2*Prescale cycles)
//   undefined - one stop bit
//
// Ports:
//   clk        system clock, all logic on the rising edge
//   reset_n    synchronous active-low reset
//   Prescale   clk cycles per bit, latched at acceptance
//   P_DATA     word to transmit
//   Data_Valid request to send P_DATA (ignored while Busy)
//   PAR_EN     1 = append a parity bit, latched at acceptance
//   PAR_TYP    0 = even, 1 = odd parity, latched at acceptance
//   TX_OUT     serial line, idle high, registered
//   Busy       high while a frame is in progress, registered
module uart_tx #(
    parameter int DATA_WIDTH     = 8,
    parameter int Prescale_width = 6
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [Prescale_width-1:0] Prescale,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      PAR_EN,
    input  logic                      PAR_TYP,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int IDX_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [Prescale_width-1:0] PS_ONE   = 1;
    localparam logic [IDX_W-1:0]          IDX_ONE  = 1;
    localparam logic [IDX_W-1:0]          IDX_LAST = IDX_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t                    state_q;
    logic [Prescale_width-1:0] cnt_q;
    logic [Prescale_width-1:0] prescale_q;
    logic [IDX_W-1:0]          bit_idx_q;
    logic [DATA_WIDTH-1:0]     data_q;
    logic                      par_en_q;
    logic                      par_bit_q;
    logic                      tx_q;
    logic                      busy_q;
`ifdef UART_TX_STOP2_EN
    logic                      stop2_q;
`endif

    // Last cycle of the current bit period.
    logic bit_end;
    assign bit_end = (cnt_q == prescale_q - PS_ONE);

    assign TX_OUT = tx_q;
    assign Busy   = busy_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            prescale_q <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_en_q   <= 1'b0;
            par_bit_q  <= 1'b0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
`ifdef UART_TX_STOP2_EN
            stop2_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    tx_q      <= 1'b1;
                    busy_q    <= 1'b0;
                    cnt_q     <= '0;
                    bit_idx_q <= '0;
                    if (Data_Valid) begin
                        data_q     <= P_DATA;
                        prescale_q <= (Prescale == '0) ? PS_ONE : Prescale;
                        par_en_q   <= PAR_EN;
                        par_bit_q  <= (^P_DATA) ^ PAR_TYP;
`ifdef UART_TX_STOP2_EN
                        stop2_q    <= 1'b0;
`endif
                        state_q    <= START;
                        tx_q       <= 1'b0;
                        busy_q     <= 1'b1;
                    end
                end
                START: begin
                    if (bit_end) begin
                        // data_q is a shift register: bit 0 is always the next bit out.
                        cnt_q     <= '0;
                        bit_idx_q <= '0;
                        tx_q      <= data_q[0];
                        data_q    <= data_q >> 1;
                        state_q   <= DATA;
                    end else begin
                        cnt_q <= cnt_q + PS_ONE;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        cnt_q <= '0;
                        if (bit_idx_q == IDX_LAST) begin
                            if (par_en_q) begin
                                tx_q    <= par_bit_q;
                                state_q <= PARITY;
                            end else begin
                                tx_q    <= 1'b1;
                                state_q <= STOP;
                            end
                        end else begin
                            bit_idx_q <= bit_idx_q + IDX_ONE;
                            tx_q      <= data_q[0];
                            data_q    <= data_q >> 1;
                        end
                    end else begin
                        cnt_q <= cnt_q + PS_ONE;
                    end
                end
                PARITY: begin
                    if (bit_end) begin
                        cnt_q   <= '0;
                        tx_q    <= 1'b1;
                        state_q <= STOP;
                    end else begin
                        cnt_q <= cnt_q + PS_ONE;
                    end
                end
                STOP: begin
                    if (bit_end) begin
                        cnt_q <= '0;
`ifdef UART_TX_STOP2_EN
                        // First stop period done: run a second one before idling.
                        if (!stop2_q) begin
                            stop2_q <= 1'b1;
                        end else begin
                            stop2_q <= 1'b0;
                            busy_q  <= 1'b0;
                            state_q <= IDLE;
                        end
`else
                        busy_q  <= 1'b0;
                        state_q <= IDLE;
`endif
                    end else begin
                        cnt_q <= cnt_q + PS_ONE;
                    end
                end
                default: begin
                    tx_q    <= 1'b1;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
